// File: rtl/crono_pkg.sv
// Shared types and command codes for the multi-channel stopwatch/timer controller.
package crono_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_REQ_START  = 4'd1,
    ST_WR_START   = 4'd2,
    ST_RUN        = 4'd3,
    ST_REQ_STOP   = 4'd4,
    ST_WR_STOP    = 4'd5,
    ST_RING       = 4'd6,
    ST_REQ_CANCEL = 4'd7,
    ST_WR_CANCEL  = 4'd8
  } ch_state_t;

  localparam logic [2:0] CMD_START = 3'b101;
  localparam logic [2:0] CMD_STOP  = 3'b110;
  localparam logic [2:0] CMD_NONE  = 3'b000;

endpackage

// File: rtl/crono_ch.sv
// One timer channel: push edge detector plus start/run/stop/ring sequencing.
// Optional CRONO_RING_TIMEOUT_EN adds an auto-silence counter on the ring state.
module crono_ch
  import crono_pkg::*;
#(
  parameter int RING_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_crono_end,
  input  logic i_gnt,
  input  logic i_expire,
  output logic o_req,
  output logic o_req_start,
  output logic o_ring
);

  ch_state_t r_state;
  ch_state_t w_state_nxt;
  logic      r_push;
  logic      r_arm;
  logic      w_edge;
  logic      w_ring_done;

  // r_arm masks the first cycle after reset so a button held across reset release is not an edge
  assign w_edge = i_push & ~r_push & r_arm;

`ifdef CRONO_RING_TIMEOUT_EN
  localparam int RW = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
  logic [RW-1:0] r_ring_cnt;

  assign w_ring_done = (r_ring_cnt == RW'(RING_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset || r_state != ST_RING) begin
      r_ring_cnt <= '0;
    end else if (!w_ring_done) begin
      r_ring_cnt <= r_ring_cnt + 1'b1;
    end
  end
`else
  // Without the timeout only a push ends the ring; a degenerate RING_CYCLES never occurs.
  assign w_ring_done = (RING_CYCLES < 1);
`endif

  always_comb begin
    o_req       = 1'b0;
    o_req_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req       = w_edge;
        o_req_start = w_edge;
      end
      ST_REQ_START: begin
        o_req       = 1'b1;
        o_req_start = 1'b1;
      end
      ST_RUN:                     o_req = i_crono_end | w_edge;
      ST_REQ_STOP, ST_REQ_CANCEL: o_req = 1'b1;
      default:                    o_req = 1'b0;
    endcase
  end

  // A request raised this cycle may be granted in the same cycle, skipping the REQ_* state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       if (w_edge) w_state_nxt = i_gnt ? ST_WR_START : ST_REQ_START;
      ST_REQ_START:  if (i_gnt) w_state_nxt = ST_WR_START;
      ST_WR_START:   if (i_expire) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_crono_end)  w_state_nxt = i_gnt ? ST_WR_STOP : ST_REQ_STOP;
        else if (w_edge)  w_state_nxt = i_gnt ? ST_WR_CANCEL : ST_REQ_CANCEL;
      end
      ST_REQ_STOP:   if (i_gnt) w_state_nxt = ST_WR_STOP;
      ST_WR_STOP:    if (i_expire) w_state_nxt = ST_RING;
      ST_RING:       if (w_edge || w_ring_done) w_state_nxt = ST_IDLE;
      ST_REQ_CANCEL: if (i_gnt) w_state_nxt = ST_WR_CANCEL;
      ST_WR_CANCEL:  if (i_expire) w_state_nxt = ST_IDLE;
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_push  <= 1'b0;
      r_arm   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_push  <= i_push;
      r_arm   <= 1'b1;
    end
  end

  assign o_ring = (r_state == ST_RING);

endmodule

// File: rtl/crono_multi_ctrl.sv
// N_CH timer channels sharing one RTC write port via a round-robin arbiter.
// Optional CRONO_RING_TIMEOUT_EN (in crono_ch) auto-silences ringing channels.
module crono_multi_ctrl
  import crono_pkg::*;
#(
  parameter int                N_CH        = 2,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                HOLD        = 511,
  parameter int                RING_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   push,
  input  logic [N_CH-1:0]   crono_end,
  output logic              wr_inistop,
  output logic [2:0]        inistop,
  output logic [ADDR_W-1:0] dir,
  output logic              wr_busy,
  output logic [N_CH-1:0]   ring
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int HW = $clog2(HOLD + 1);

  logic [N_CH-1:0]   w_req;
  logic [N_CH-1:0]   w_req_start;
  logic [N_CH-1:0]   w_gnt;
  logic              w_gnt_vld;
  logic [PW-1:0]     w_gnt_idx;
  logic              w_expire;
  int                w_idx;

  logic [PW-1:0]     r_ptr;
  logic              r_wr;
  logic              r_busy;
  logic [2:0]        r_cmd;
  logic [ADDR_W-1:0] r_dir;
  logic [HW-1:0]     r_hold;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    crono_ch #(
      .RING_CYCLES(RING_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_push     (push[k]),
      .i_crono_end(crono_end[k]),
      .i_gnt      (w_gnt[k]),
      .i_expire   (w_expire),
      .o_req      (w_req[k]),
      .o_req_start(w_req_start[k]),
      .o_ring     (ring[k])
    );
  end

  assign w_expire = r_wr && (r_hold == HW'(HOLD));

  // Bus is free when idle or in the gap cycle; scanning downwards leaves the nearest requester.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N_CH) w_idx = w_idx - N_CH;
      if (w_req[PW'(w_idx)] && !r_wr) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PW'(w_idx);
      end
    end
    if (w_gnt_vld) w_gnt[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr  <= '0;
      r_wr   <= 1'b0;
      r_busy <= 1'b0;
      r_cmd  <= CMD_NONE;
      r_dir  <= '0;
      r_hold <= '0;
    end else if (w_gnt_vld) begin
      r_wr   <= 1'b1;
      r_busy <= 1'b1;
      r_cmd  <= w_req_start[w_gnt_idx] ? CMD_START : CMD_STOP;
      r_dir  <= BASE_ADDR + ADDR_W'(w_gnt_idx);
      r_hold <= HW'(1);
      r_ptr  <= (w_gnt_idx == PW'(N_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
    end else if (w_expire) begin
      r_wr  <= 1'b0;
      r_cmd <= CMD_NONE;
    end else if (r_wr) begin
      r_hold <= r_hold + 1'b1;
    end else begin
      r_busy <= 1'b0;
      r_hold <= '0;
    end
  end

  assign wr_inistop = r_wr;
  assign inistop    = r_cmd;
  assign dir        = r_dir;
  assign wr_busy    = r_busy;

endmodule

// File: tb/tb_crono_multi_ctrl.sv
// Bench for crono_multi_ctrl: directed test-plan scenarios then random traffic, all against a transaction-level model.
module tb_crono_multi_ctrl;

  localparam int          N_CH = 2;
  localparam int          HOLD = 4;
  localparam int          RC   = 8;
  localparam logic [7:0]  BASE = 8'h40;

  localparam int M_IDLE = 0, M_WAIT = 1, M_WR = 2, M_RUN = 3, M_RING = 4;
  localparam int K_START = 1, K_STOP = 2, K_CANCEL = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N_CH-1:0] push = '0;
  logic [N_CH-1:0] crono_end = '0;
  logic            wr_inistop;
  logic [2:0]      inistop;
  logic [7:0]      dir;
  logic            wr_busy;
  logic [N_CH-1:0] ring;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // model state: per-channel activity, pending write kind, ring age; bus = cycle index of the current write
  int m_mode [N_CH];
  int m_kind [N_CH];
  int m_rcnt [N_CH];
  bit m_prev [N_CH];
  bit m_arm;
  int m_bus, m_owner, m_ptr, m_dir, m_cmd;

  always #5 clk = ~clk;

  crono_multi_ctrl #(
    .N_CH(N_CH), .ADDR_W(8), .BASE_ADDR(BASE), .HOLD(HOLD), .RING_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .crono_end(crono_end),
    .wr_inistop(wr_inistop), .inistop(inistop), .dir(dir),
    .wr_busy(wr_busy), .ring(ring)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
  endtask

  task automatic model_step();
    bit e;
    bit free_bus;
    bit granted;
    if (!reset) begin
      for (int k = 0; k < N_CH; k++) begin
        m_mode[k] = M_IDLE; m_kind[k] = 0; m_rcnt[k] = 0; m_prev[k] = 0;
      end
      m_arm = 0; m_bus = 0; m_owner = 0; m_ptr = 0; m_dir = 0; m_cmd = 0;
      return;
    end
    for (int k = 0; k < N_CH; k++) begin
      e = push[k] && !m_prev[k] && m_arm;
      if (m_mode[k] == M_IDLE && e) begin
        m_mode[k] = M_WAIT; m_kind[k] = K_START;
      end else if (m_mode[k] == M_RUN && crono_end[k]) begin
        m_mode[k] = M_WAIT; m_kind[k] = K_STOP;
      end else if (m_mode[k] == M_RUN && e) begin
        m_mode[k] = M_WAIT; m_kind[k] = K_CANCEL;
      end else if (m_mode[k] == M_RING) begin
        if (e) m_mode[k] = M_IDLE;
`ifdef CRONO_RING_TIMEOUT_EN
        else if (m_rcnt[k] == RC - 1) m_mode[k] = M_IDLE;
        else m_rcnt[k]++;
`endif
      end
    end
    free_bus = (m_bus == 0) || (m_bus == HOLD + 1);
    if (m_bus == HOLD) begin
      case (m_kind[m_owner])
        K_START: m_mode[m_owner] = M_RUN;
        K_STOP:  begin m_mode[m_owner] = M_RING; m_rcnt[m_owner] = 0; end
        default: m_mode[m_owner] = M_IDLE;
      endcase
      m_bus = HOLD + 1;
    end else if (m_bus > 0 && m_bus < HOLD) begin
      m_bus++;
    end else begin
      m_bus = 0;
    end
    granted = 0;
    if (free_bus) begin
      for (int off = 0; off < N_CH; off++) begin
        int j;
        j = (m_ptr + off) % N_CH;
        if (!granted && m_mode[j] == M_WAIT) begin
          granted = 1;
          m_mode[j] = M_WR; m_owner = j; m_bus = 1;
          m_cmd = (m_kind[j] == K_START) ? 5 : 6;
          m_dir = (BASE + j) % 256;
          m_ptr = (j + 1) % N_CH;
        end
      end
    end
    for (int k = 0; k < N_CH; k++) m_prev[k] = push[k];
    m_arm = 1;
  endtask

  task automatic check_outputs();
    logic [N_CH-1:0] er;
    bit strobe;
    strobe = (m_bus >= 1) && (m_bus <= HOLD);
    for (int k = 0; k < N_CH; k++) er[k] = (m_mode[k] == M_RING);
    check("wr_inistop", wr_inistop, strobe);
    check("inistop", inistop, strobe ? m_cmd : 0);
    check("dir", dir, m_dir);
    check("wr_busy", wr_busy, m_bus != 0);
    check("ring", ring, er);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      check_outputs();
    end
  endtask

  initial begin
    int ring_cnt;
    int ring_exp;

    // reset state
    tick(3);
    check("rst_wr", wr_inistop, 0);
    check("rst_busy", wr_busy, 0);
    check("rst_dir", dir, 0);
    reset = 1'b1;
    tick(6);

    // start write latency and timing
    push[0] = 1'b1; tick();
    check("start_strobe", wr_inistop, 1);
    check("start_cmd", inistop, 3'b101);
    check("start_dir", dir, 8'h40);
    push[0] = 1'b0; tick(3);
    check("start_last", wr_inistop, 1);
    tick();
    check("gap_strobe", wr_inistop, 0);
    check("gap_busy", wr_busy, 1);
    tick();
    check("busy_fall", wr_busy, 0);

    // stop by crono_end, ring, push clears ring
    crono_end[0] = 1'b1; tick();
    check("stop_cmd", inistop, 3'b110);
    check("stop_dir", dir, 8'h40);
    crono_end[0] = 1'b0; tick(4);
    check("ring0_on", ring[0], 1);
    tick(2);
    push[0] = 1'b1; tick();
    check("ring0_off", ring[0], 0);
    push[0] = 1'b0; tick();

    // channel 1 start leaves pointer at 0, then contention
    push[1] = 1'b1; tick();
    check("ch1_dir", dir, 8'h41);
    push[1] = 1'b0; tick(5);
    push = 2'b11; tick();
    check("cont_first_dir", dir, 8'h40);
    check("cont_first_cmd", inistop, 3'b101);
    push = 2'b00; tick(4);
    tick();
    check("cont_second_strobe", wr_inistop, 1);
    check("cont_second_dir", dir, 8'h41);
    check("cont_second_cmd", inistop, 3'b110);
    tick(5);
    check("cancel_no_ring", ring[1], 0);

    // coincident push and crono_end in RUN: stop wins, ring
    push[1] = 1'b1; tick();
    push[1] = 1'b0; tick(5);
    push[1] = 1'b1; crono_end[1] = 1'b1; tick();
    push[1] = 1'b0; crono_end[1] = 1'b0; tick(4);
    check("coinc_ring1", ring[1], 1);
    push[1] = 1'b1; tick();
    push[1] = 1'b0; tick();

    // reset in cycle 2 of a write, push held across release
    crono_end[0] = 1'b1; tick();
    crono_end[0] = 1'b0; tick();
    reset = 1'b0; push = 2'b11; tick();
    check("midrst_wr", wr_inistop, 0);
    check("midrst_busy", wr_busy, 0);
    check("midrst_cmd", inistop, 0);
    check("midrst_ring", ring, 0);
    tick(2);
    reset = 1'b1; tick(10);
    check("held_push_nowrite", wr_busy, 0);
    push = 2'b00; tick(2);

    // ring duration with no push
    push[0] = 1'b1; tick();
    push[0] = 1'b0; tick(5);
    crono_end[0] = 1'b1; tick();
    crono_end[0] = 1'b0; tick(3);
    ring_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ring_cnt += int'(ring[0]);
    end
`ifdef CRONO_RING_TIMEOUT_EN
    ring_exp = RC;
`else
    ring_exp = 20;
`endif
    check("ring_len", ring_cnt, ring_exp);
    push[0] = 1'b1; tick();
    push[0] = 1'b0; tick(2);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N_CH; k++) begin
        if ($urandom_range(0, 5) == 0) push[k] = ~push[k];
        crono_end[k] = ($urandom_range(0, 9) == 0);
      end
      reset = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
